// File: rtl/four_12_12_st3_mem_ctrl.sv
// -----------------------------------------------------------------------------
// four_12_12_st3_mem_ctrl
//
// Initiator of the stage-3 data memory port. The external single-port-pair
// memory is used as a circular FIFO between a valid/ready write stream and a
// valid/ready read stream. Memory reads have a fixed one-cycle latency, so the
// output side keeps a 2-entry skid buffer plus an in-flight flag. Reads are
// only issued when the skid buffer is guaranteed to have room for the returning
// word, so no returned word can ever be dropped.
//
// Parameters
//   DATA_W  memory word width
//   ADDR_W  memory address width
//   DEPTH   number of memory words (must equal 2**ADDR_W)
//
// Ports
//   clk          single clock for all logic
//   reset        asynchronous, active-low reset
//   flush        synchronous clear of pointers, counts and buffers
//   in_valid     write-stream word present
//   in_data      write-stream word
//   in_ready     block accepts in_data this cycle
//   out_valid    read-stream word present
//   out_data     read-stream word (oldest buffered entry)
//   out_ready    consumer accepts out_data this cycle
//   mem_wr_en    memory write strobe
//   mem_wr_addr  memory write address
//   mem_wr_data  memory write data
//   mem_rd_en    memory read strobe
//   mem_rd_addr  memory read address
//   mem_rd_data  memory read data, valid one cycle after mem_rd_en
//   level        registered count of words held (memory + in flight + buffer)
// -----------------------------------------------------------------------------
module four_12_12_st3_mem_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 512
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [ADDR_W:0]   level
);

    localparam logic [ADDR_W:0]   L_DEPTH     = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   L_CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] L_PTR_LAST  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] L_PTR_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W:0]   L_LEVEL_MAX = '1;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_mem_cnt;
    logic [1:0]        r_obuf_cnt;
    logic              r_infl;
    logic [DATA_W-1:0] r_obuf_head;   // oldest entry, drives out_data
    logic [DATA_W-1:0] r_obuf_tail;   // second entry, valid when r_obuf_cnt == 2
    logic [ADDR_W:0]   r_level;

    // -------------------------------------------------------------------------
    // Handshake decode
    // -------------------------------------------------------------------------
    logic              w_in_ready;
    logic              w_wr;
    logic              w_pop;
    logic              w_push;
    logic [2:0]        w_occ;
    logic              w_rd;
    logic              w_push_to_tail;

    assign w_in_ready = (r_mem_cnt != L_DEPTH) && !flush;
    assign w_wr       = in_valid && w_in_ready;
    assign w_pop      = (r_obuf_cnt != 2'd0) && out_ready;

    // A returning word is only captured outside flush; data arriving in the
    // flush cycle belongs to the stream being discarded.
    assign w_push     = r_infl && !flush;

    // Slots already claimed in the skid buffer (held + the word in flight).
    // A pop this cycle frees one slot, so it counts toward room for a new read.
    assign w_occ      = {1'b0, r_obuf_cnt} + {2'b00, r_infl};
    assign w_rd       = (r_mem_cnt != '0) && !flush
                        && ((w_occ - {2'b00, w_pop}) < 3'd2);

    // The returning word lands behind whatever remains after this cycle's pop.
    assign w_push_to_tail = (r_obuf_cnt == 2'd2)
                            || ((r_obuf_cnt == 2'd1) && !w_pop);

    // -------------------------------------------------------------------------
    // Next-state computation
    // -------------------------------------------------------------------------
    logic [ADDR_W-1:0] w_wr_ptr_nxt;
    logic [ADDR_W-1:0] w_rd_ptr_nxt;
    logic [ADDR_W:0]   w_mem_cnt_nxt;
    logic [1:0]        w_obuf_cnt_nxt;
    logic              w_infl_nxt;
    logic [ADDR_W+1:0] w_level_sum;
    logic [ADDR_W:0]   w_level_nxt;

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        w_wr_ptr_nxt   = r_wr_ptr;
        w_rd_ptr_nxt   = r_rd_ptr;
        w_mem_cnt_nxt  = r_mem_cnt;
        w_obuf_cnt_nxt = r_obuf_cnt;
        w_infl_nxt     = 1'b0;

        if (flush) begin
            w_wr_ptr_nxt   = '0;
            w_rd_ptr_nxt   = '0;
            w_mem_cnt_nxt  = '0;
            w_obuf_cnt_nxt = 2'd0;
            w_infl_nxt     = 1'b0;
        end else begin
            if (w_wr) begin
                w_wr_ptr_nxt = (r_wr_ptr == L_PTR_LAST) ? '0 : r_wr_ptr + L_PTR_ONE;
            end
            if (w_rd) begin
                w_rd_ptr_nxt = (r_rd_ptr == L_PTR_LAST) ? '0 : r_rd_ptr + L_PTR_ONE;
            end

            // Simultaneous write and read leave the memory occupancy unchanged.
            unique case ({w_wr, w_rd})
                2'b10:   w_mem_cnt_nxt = r_mem_cnt + L_CNT_ONE;
                2'b01:   w_mem_cnt_nxt = r_mem_cnt - L_CNT_ONE;
                default: w_mem_cnt_nxt = r_mem_cnt;
            endcase

            unique case ({w_push, w_pop})
                2'b10:   w_obuf_cnt_nxt = r_obuf_cnt + 2'd1;
                2'b01:   w_obuf_cnt_nxt = r_obuf_cnt - 2'd1;
                default: w_obuf_cnt_nxt = r_obuf_cnt;
            endcase

            w_infl_nxt = w_rd;
        end
    end

    // level is registered from the next-state counts so that, after each edge,
    // it equals exactly mem_cnt + infl + obuf_cnt of the current cycle.
    always_comb begin
        w_level_sum = {1'b0, w_mem_cnt_nxt}
                      + (ADDR_W+2)'(w_obuf_cnt_nxt)
                      + (ADDR_W+2)'(w_infl_nxt);
        w_level_nxt = w_level_sum[ADDR_W+1] ? L_LEVEL_MAX : w_level_sum[ADDR_W:0];
    end

    // -------------------------------------------------------------------------
    // Pointer / count registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state is updated only with non-blocking assignments so
    // every register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_mem_cnt  <= '0;
            r_obuf_cnt <= 2'd0;
            r_infl     <= 1'b0;
            r_level    <= '0;
        end else begin
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_mem_cnt  <= w_mem_cnt_nxt;
            r_obuf_cnt <= w_obuf_cnt_nxt;
            r_infl     <= w_infl_nxt;
            r_level    <= w_level_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Skid buffer
    // -------------------------------------------------------------------------
    // NOTE: the external memory array is never cleared; only these two small
    // buffer registers are reset, because out_data must read 0 after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_obuf_head <= '0;
            r_obuf_tail <= '0;
        end else if (flush) begin
            r_obuf_head <= '0;
            r_obuf_tail <= '0;
        end else begin
            // Pop shifts the second entry forward; a push into the head slot
            // below takes precedence when the buffer ends up with one entry.
            if (w_pop) begin
                r_obuf_head <= r_obuf_tail;
            end
            if (w_push) begin
                if (w_push_to_tail) begin
                    r_obuf_tail <= mem_rd_data;
                end else begin
                    r_obuf_head <= mem_rd_data;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign in_ready    = w_in_ready;
    assign out_valid   = (r_obuf_cnt != 2'd0);
    assign out_data    = r_obuf_head;
    assign mem_wr_en   = w_wr;
    assign mem_wr_addr = r_wr_ptr;
    assign mem_wr_data = in_data;
    assign mem_rd_en   = w_rd;
    assign mem_rd_addr = r_rd_ptr;
    assign level       = r_level;

endmodule

// File: tb/tb_four_12_12_st3_mem_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for four_12_12_st3_mem_ctrl.
// Inputs are driven 1 time unit after the rising edge; everything is sampled on
// the falling edge. The stimulus side pushes each accepted word into exp_q; an
// independent monitor pops and compares on every output transfer and also
// tracks expected memory addresses, the expected level and output stability.
// -----------------------------------------------------------------------------
module tb_four_12_12_st3_mem_ctrl;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 9;
    localparam int DEPTH  = 512;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_rd_data;
    logic [ADDR_W:0]   level;

    logic rdy_manual = 1'b0;
    logic rdy_rand   = 1'b0;
    logic rand_mode  = 1'b0;
    assign out_ready = rand_mode ? rdy_rand : rdy_manual;

    int n_checks = 0;
    int n_errors = 0;
    int n_pops   = 0;

    logic [DATA_W-1:0] exp_q[$];

    always #5 clk = ~clk;

    four_12_12_st3_mem_ctrl #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .mem_wr_en  (mem_wr_en),
        .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data),
        .mem_rd_en  (mem_rd_en),
        .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data),
        .level      (level)
    );

    // Memory model: synchronous write, one-cycle read latency.
    logic [DATA_W-1:0] mem_model [DEPTH];
    always @(posedge clk) begin
        if (mem_wr_en) mem_model[mem_wr_addr] <= mem_wr_data;
        if (mem_rd_en) mem_rd_data <= mem_model[mem_rd_addr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Monitor / scoreboard
    // -------------------------------------------------------------------------
    logic [ADDR_W-1:0] exp_wa = '0;
    logic [ADDR_W-1:0] exp_ra = '0;
    int                n_held = 0;
    logic              prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data  = '0;

    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
            exp_wa     = '0;
            exp_ra     = '0;
            n_held     = 0;
            prev_stall = 1'b0;
        end else begin
            check("level", 64'(level), 64'(n_held));
            check("wr_en", 64'(mem_wr_en), 64'(in_valid && in_ready));
            if (prev_stall) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_data", 64'(out_data), 64'(prev_data));
            end
            if (flush) begin
                check("flush_wr_en", 64'(mem_wr_en), 64'd0);
                check("flush_rd_en", 64'(mem_rd_en), 64'd0);
                exp_q.delete();
                exp_wa     = '0;
                exp_ra     = '0;
                n_held     = 0;
                prev_stall = 1'b0;
            end else begin
                if (mem_wr_en) begin
                    check("wr_addr", 64'(mem_wr_addr), 64'(exp_wa));
                    exp_wa = exp_wa + 1'b1;
                    n_held++;
                end
                if (mem_rd_en) begin
                    check("rd_addr", 64'(mem_rd_addr), 64'(exp_ra));
                    exp_ra = exp_ra + 1'b1;
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL out_data: got 0x%0h expected no word at %0t", out_data, $time);
                    end else begin
                        check("out_data", 64'(out_data), 64'(exp_q.pop_front()));
                    end
                    n_held--;
                    n_pops++;
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
            end
        end
    end

    // Random out_ready source, used only while rand_mode is set.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            rdy_rand = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers
    // -------------------------------------------------------------------------
    task automatic drive_word(input logic [DATA_W-1:0] d);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int k = 0; k < 2000 && !ok; k++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(d);
                ok = 1'b1;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1 for 0x%0h", d);
        end else begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        bit done = 1'b0;
        for (int k = 0; k < 5000 && !done; k++) begin
            @(negedge clk);
            if (level == '0 && exp_q.size() == 0) done = 1'b1;
        end
        check(name, 64'(done), 64'd1);
        @(posedge clk);
        #1;
    endtask

    // Five words in, then one pop with one more write: leaves obuf=1, infl=1,
    // mem_cnt=3, so level=5 with a read in flight.
    task automatic setup_midstream(input logic [DATA_W-1:0] base);
        rdy_manual = 1'b0;
        for (int i = 0; i < 5; i++) drive_word(base + DATA_W'(i));
        rdy_manual = 1'b1;
        drive_word(base + 32'd5);
        rdy_manual = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    // Directed sequence
    // -------------------------------------------------------------------------
    initial begin
        int snap;
        reset    = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;

        // Reset state.
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_level", 64'(level), 64'd0);
        check("rst_wr_en", 64'(mem_wr_en), 64'd0);
        check("rst_rd_en", 64'(mem_rd_en), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Single word: read issued next cycle, out_valid two cycles after that.
        drive_word(32'hDEAD_BEEF);
        @(negedge clk);
        check("sw_rd_en", 64'(mem_rd_en), 64'd1);
        check("sw_rd_addr", 64'(mem_rd_addr), 64'd0);
        check("sw_level", 64'(level), 64'd1);
        @(negedge clk);
        check("sw_valid_early", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("sw_valid", 64'(out_valid), 64'd1);
        check("sw_data", 64'(out_data), 64'hDEAD_BEEF);
        check("sw_level2", 64'(level), 64'd1);
        @(posedge clk);
        #1;
        rdy_manual = 1'b1;
        drain("sw_drain");

        // Fill: 514 words, consumer stalled.
        rdy_manual = 1'b0;
        for (int i = 0; i < 514; i++) drive_word(DATA_W'(i));
        @(negedge clk);
        check("fill_in_ready", 64'(in_ready), 64'd0);
        check("fill_level", 64'(level), 64'd514);
        check("fill_out_valid", 64'(out_valid), 64'd1);
        check("fill_out_data", 64'(out_data), 64'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = 32'hFFFF_FFFF;
        @(negedge clk);
        check("fill_blocked", 64'(mem_wr_en), 64'd0);
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        rdy_manual = 1'b1;
        drain("fill_drain");

        // Streaming: 600 back-to-back words with the consumer always ready.
        rdy_manual = 1'b1;
        snap = n_pops;
        for (int i = 0; i < 600; i++) drive_word(32'h2000_0000 + DATA_W'(i));
        check("stream_pops", 64'(n_pops - snap), 64'd597);
        drain("stream_drain");

        // Backpressure: out_ready toggles every cycle.
        rdy_manual = 1'b0;
        snap = n_pops;
        for (int i = 0; i < 8; i++) drive_word(32'h0000_0100 + DATA_W'(i));
        for (int k = 0; k < 200; k++) begin
            rdy_manual = ~rdy_manual;
            @(negedge clk);
            if (level == '0) break;
            @(posedge clk);
            #1;
        end
        check("bp_pops", 64'(n_pops - snap), 64'd8);
        @(posedge clk);
        #1;
        rdy_manual = 1'b1;
        drain("bp_drain");

        // Wrap: 1000 words with random gaps and random consumer readiness.
        snap = n_pops;
        rand_mode = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            int gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                @(posedge clk);
                #1;
            end
            drive_word(32'h1000_0000 + DATA_W'(i));
        end
        rand_mode  = 1'b0;
        rdy_manual = 1'b1;
        drain("wrap_drain");
        check("wrap_pops", 64'(n_pops - snap), 64'd1000);

        // Flush mid-stream with a read in flight.
        setup_midstream(32'h3000_0000);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h0BAD_0BAD;
        @(negedge clk);
        check("fl_pre_level", 64'(level), 64'd5);
        check("fl_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("fl_level", 64'(level), 64'd0);
        check("fl_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        rdy_manual = 1'b1;
        drive_word(32'hA5A5_0001);
        drain("fl_drain");

        // Reset mid-stream with a read in flight.
        setup_midstream(32'h4000_0000);
        reset = 1'b0;
        @(negedge clk);
        check("mr_level", 64'(level), 64'd0);
        check("mr_out_valid", 64'(out_valid), 64'd0);
        check("mr_out_data", 64'(out_data), 64'd0);
        check("mr_in_ready", 64'(in_ready), 64'd1);
        check("mr_rd_en", 64'(mem_rd_en), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("mr_level_after", 64'(level), 64'd0);
        @(posedge clk);
        #1;
        rdy_manual = 1'b1;
        drive_word(32'hA5A5_0002);
        drain("mr_drain");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
